// File: rtl/lii_rx_unpack_if.sv
// LII receive bundle: one packed phy input channel plus the two unpacked
// kernel streams (data, label). The upstream phy and the downstream kernel
// sit on the master side. The unpacker sits on the slave side.
interface lii_rx_unpack_if #(
  parameter int PW = 128,
  parameter int DW = 16,
  parameter int LW = 8
);
  // packed phy input channel
  logic [PW-1:0] lii_in_p0_tdata;
  logic          lii_in_p0_tvalid;
  logic          lii_in_p0_tready;
  logic [7:0]    lii_in_p0_src;
  logic [7:0]    lii_in_p0_dst;

  // unpacked kernel streams
  logic [DW-1:0] data_stream_tdata;
  logic          data_stream_tvalid;
  logic          data_stream_tready;
  logic [LW-1:0] label_stream_tdata;
  logic          label_stream_tvalid;
  logic          label_stream_tready;

  // environment side: drives the phy word, consumes both streams
  modport master (
    output lii_in_p0_tdata,
    output lii_in_p0_tvalid,
    input  lii_in_p0_tready,
    output lii_in_p0_src,
    output lii_in_p0_dst,
    input  data_stream_tdata,
    input  data_stream_tvalid,
    output data_stream_tready,
    input  label_stream_tdata,
    input  label_stream_tvalid,
    output label_stream_tready
  );

  // unpacker side
  modport slave (
    input  lii_in_p0_tdata,
    input  lii_in_p0_tvalid,
    output lii_in_p0_tready,
    input  lii_in_p0_src,
    input  lii_in_p0_dst,
    output data_stream_tdata,
    output data_stream_tvalid,
    input  data_stream_tready,
    output label_stream_tdata,
    output label_stream_tvalid,
    input  label_stream_tready
  );
endinterface

// File: rtl/lii_rx_unpack.sv
// LII phy receiver for the spam-filter memory partition.
// Buffers packed phy words in a DEPTH-entry first-word-fall-through FIFO.
// Forks the head word into a data stream (bits [LW+DW-1:LW]) and a label
// stream (bits [LW-1:0]). Each branch consumes the head independently, and
// the word is popped once both branches have taken it.
// The kernel clock enable ce is high while a head word is present.
// Optional build macro LII_DST_FILTER_EN: words whose dst differs from MY_ID
// are accepted but discarded. They are counted on a saturating drop_cnt port.
module lii_rx_unpack #(
  parameter int         PW    = 128,
  parameter int         DW    = 16,
  parameter int         LW    = 8,
  parameter int         DEPTH = 4,
  parameter logic [7:0] MY_ID = 8'h01
) (
  input  logic                aclk,
  input  logic                arstn,
  lii_rx_unpack_if.slave      bus,
  output logic                ce
`ifdef LII_DST_FILTER_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // storage and control state
  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          done_dat_q, done_dat_d;
  logic          done_lbl_q, done_lbl_d;

  logic [PW-1:0] head_w;
  logic          nempty_w;
  logic          full_w;
  logic          in_ready_w;
  logic          accept_w;
  logic          push_w;
  logic          pop_w;
  logic          dat_valid_w;
  logic          lbl_valid_w;
  logic          take_dat_w;
  logic          take_lbl_w;

  assign head_w   = mem_q[rd_ptr_q];
  assign nempty_w = (count_q != '0);
  assign full_w   = (count_q == CW'(DEPTH));

  // Ready depends only on the registered occupancy; it never looks at the
  // downstream readies, so a full FIFO stays not-ready even in a pop cycle.
  // Holding it low while arstn is asserted keeps the phy from handing over
  // a word that would be lost.
  assign in_ready_w           = arstn & ~full_w;
  assign bus.lii_in_p0_tready = in_ready_w;
  assign accept_w             = bus.lii_in_p0_tvalid & in_ready_w;

`ifdef LII_DST_FILTER_EN
  logic        dst_ok_w;
  logic        drop_w;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        unused_bits_w;

  // Saturating increment for the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  assign dst_ok_w = (bus.lii_in_p0_dst == MY_ID);
  assign push_w   = accept_w & dst_ok_w;
  assign drop_w   = accept_w & ~dst_ok_w;
  assign drop_cnt = drop_cnt_q;

  // drop counter next state
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_w) drop_cnt_d = sat_inc16(drop_cnt_q);
  end

  // drop counter register
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  // src sideband and the pad above the label/data fields carry nothing here
  assign unused_bits_w = ^{bus.lii_in_p0_src, head_w[PW-1:LW+DW]};
`else
  logic unused_bits_w;

  assign push_w = accept_w;

  // without the filter, dst, src and the pad bits are not consumed
  assign unused_bits_w = ^{bus.lii_in_p0_src, bus.lii_in_p0_dst, MY_ID,
                           head_w[PW-1:LW+DW]};
`endif

  // Fork: a branch sees the head until it has taken it once.
  assign dat_valid_w = nempty_w & ~done_dat_q;
  assign lbl_valid_w = nempty_w & ~done_lbl_q;
  assign take_dat_w  = dat_valid_w & bus.data_stream_tready;
  assign take_lbl_w  = lbl_valid_w & bus.label_stream_tready;
  assign pop_w       = nempty_w & (done_dat_q | take_dat_w)
                                & (done_lbl_q | take_lbl_w);

  assign bus.data_stream_tvalid  = dat_valid_w;
  assign bus.data_stream_tdata   = head_w[LW+DW-1:LW];
  assign bus.label_stream_tvalid = lbl_valid_w;
  assign bus.label_stream_tdata  = head_w[LW-1:0];

  // The kernel advances only while there is a word to work on.
  assign ce = nempty_w;

  // pointer, occupancy and fork-state next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    done_dat_d = done_dat_q | take_dat_w;
    done_lbl_d = done_lbl_q | take_lbl_w;
    if (push_w) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_w) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      done_dat_d = 1'b0;
      done_lbl_d = 1'b0;
    end
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // control registers; reset discards buffered words and partial fork state
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_dat_q <= 1'b0;
      done_lbl_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      done_dat_q <= done_dat_d;
      done_lbl_q <= done_lbl_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge aclk) begin
    if (push_w) mem_q[wr_ptr_q] <= bus.lii_in_p0_tdata;
  end

endmodule

// File: doc/lii_rx_unpack.md
Name: lii_rx_unpack

Overview:
- Consumer-side LII phy receiver for the spam-filter memory partition.
- Accepts packed PW-bit words from one LII phy input channel and buffers them in a small FIFO.
- Unpacks each word into two logical kernel streams, data (16b) and label (8b), using a per-branch fork handshake.
- Drives the downstream HLS kernel clock enable; it is the receiving counterpart of the output-pack stage that emits {data, label} words.

Parameters:
- PW, 128, packing width of the LII phy word
- DW, 16, data_stream width; occupies tdata[LW+DW-1:LW]
- LW, 8, label_stream width; occupies tdata[LW-1:0]
- DEPTH, 4, FIFO depth in words; power of 2, minimum 2
- MY_ID, 8'h01, local endpoint ID, used only when the filter feature is compiled in

Ports:
- aclk  in  1  single clock
- arstn  in  1  asynchronous active-low reset
- lii_in_p0_tdata  in  PW  packed word
- lii_in_p0_tvalid  in  1  word valid
- lii_in_p0_tready  out  1  word accepted when high with tvalid
- lii_in_p0_src  in  8  source endpoint ID, sideband, not stored
- lii_in_p0_dst  in  8  destination endpoint ID
- data_stream_tdata  out  DW  unpacked data field
- data_stream_tvalid  out  1
- data_stream_tready  in  1
- label_stream_tdata  out  LW  unpacked label field
- label_stream_tvalid  out  1
- label_stream_tready  in  1
- ce  out  1  kernel clock enable
- drop_cnt  out  16  dropped-word count; present only with LII_DST_FILTER_EN

Behaviour:
- Clock and reset: one clock, aclk. Reset arstn is asynchronous, active-low.
- Reset state: wr_ptr, rd_ptr, count, done_d, done_l and drop_cnt all clear to 0.
  - Hence lii_in_p0_tready=1 once reset is released; while arstn is low it is forced to 0.
  - Both out tvalid=0 and ce=0.
  - FIFO memory is not reset.
- Input handshake:
  - tready = (count != DEPTH), a registered-state decode with no combinational path from out treadys.
  - A push occurs on tvalid & tready.
- No full bypass: when count==DEPTH, tready=0 even if a pop occurs in the same cycle.
- Latency: a word pushed at edge N is visible on both outputs after edge N, i.e. 1 cycle, with first-word fall-through from the memory head.
- Fields: data_stream_tdata = head[LW+DW-1:LW] and label_stream_tdata = head[LW-1:0]. Bits [PW-1:LW+DW] are ignored.
- Fork:
  - done_d and done_l mark branches already consumed for the head word.
  - data_stream_tvalid = (count!=0) & !done_d, and likewise for label.
  - A branch is taken on tvalid & tready and sets its done bit unless the pop occurs.
  - pop = (count!=0) & (done_d | data take) & (done_l | label take). On pop, both done bits clear and rd_ptr advances.
  - Both branches taken in the same cycle means pop in that cycle.
  - Each branch receives every word exactly once, in order, with no duplication and no skipping.
- Count rules:
  - push & !pop: count+1
  - pop & !push: count-1
  - both: unchanged
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- ce = (count != 0), combinational from the registered count. The kernel advances only while a head word is available.
- Empty: no pop possible; treadys are ignored.
- Reset mid-operation: buffered words and partial fork state are discarded. No output glitches to tvalid=1 during reset.

Optional Feature:
- Macro: LII_DST_FILTER_EN.
- Defined:
  - A handshake with lii_in_p0_dst != MY_ID is accepted but not written (tready unchanged, no push).
  - drop_cnt increments by 1 per such word and saturates at 16'hFFFF.
  - Matching words behave as normal.
- Undefined: dst is ignored, every accepted word is pushed, and the drop_cnt port does not exist.

Test Plan:
- Single word: reset, push tdata with [23:8]=16'hBEEF and [7:0]=8'h5A, both treadys held 1 → both tvalid rise 1 cycle after push with values BEEF/5A. Pop in that cycle; count returns to 0 and ce drops.
- Skewed fork: push 16'h0001/8'h11 then 16'h0002/8'h22. Label tready=1 and data tready=0 for 3 cycles → label delivers 11 once, then label tvalid=0 while data holds 0001. Raise data tready → 0001, then both deliver the 0002 pair. No duplicate label.
- Full/backpressure with DEPTH=4: push 5 words with both treadys 0 → tready=0 after the 4th accept and the 5th is held. Take one word with both treadys 1 → tready returns 1 the next cycle. Order preserved.
- Wrap-around: stream 20 words with values 0..19, both treadys toggling pseudo-randomly → outputs are exactly 0..19 on each branch. Pointers wrap at least 4 times.
- Reset mid-operation: 3 words buffered and done_l set, then pulse arstn low asynchronously mid-cycle → tvalids and ce go 0 immediately. After release: count=0 and tready=1, and the next pushed word (0x0077/0x07) is delivered on both branches first.
- With LII_DST_FILTER_EN, MY_ID=1: push dst=1, 2, 1, 2 → only words 1 and 3 are delivered and drop_cnt=2. Preload drop_cnt near saturation → it holds at FFFF.
